// File: rtl/label_table_ctrl_if.sv
// Label table controller bus bundle: definition requests, datapath lookup port,
// table read/write port and status. The controller uses the slave modport.
interface label_table_ctrl_if;
  localparam int unsigned LBID_W  = 12;
  localparam int unsigned TYP_W   = 6;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CODE_W  = 2;

  logic              clear_req;
  logic              def_valid;
  logic              def_ready;
  logic [LBID_W-1:0] def_lbid;
  logic [TYP_W-1:0]  def_typ;
  logic [DATA_W-1:0] def_base;
  logic [DATA_W-1:0] def_count;

  logic [LBID_W-1:0] rd_lbid;
  logic              rd_stall;

  logic [LBID_W-1:0] tbl_lbid;
  logic [TYP_W-1:0]  tbl_typ;
  logic [LBID_W-1:0] tbl_lbidw;
  logic [TYP_W-1:0]  tbl_typw;
  logic [DATA_W-1:0] tbl_basew;
  logic [DATA_W-1:0] tbl_countw;
  logic              tbl_we;

  logic              busy;
  logic              err;
  logic [CODE_W-1:0] err_code;
  logic [LBID_W-1:0] err_lbid;
  logic [LBID_W-1:0] defined_cnt;

  // Environment side: prescan, datapath and table storage
  modport master (
    output clear_req, def_valid, def_lbid, def_typ, def_base, def_count,
    output rd_lbid, tbl_typ,
    input  def_ready, rd_stall, tbl_lbid, tbl_lbidw, tbl_typw, tbl_basew,
    input  tbl_countw, tbl_we, busy, err, err_code, err_lbid, defined_cnt
  );

  // Controller side
  modport slave (
    input  clear_req, def_valid, def_lbid, def_typ, def_base, def_count,
    input  rd_lbid, tbl_typ,
    output def_ready, rd_stall, tbl_lbid, tbl_lbidw, tbl_typw, tbl_basew,
    output tbl_countw, tbl_we, busy, err, err_code, err_lbid, defined_cnt
  );
endinterface

// File: rtl/label_table_ctrl.sv
// Label table write-side controller: clear sweep, definition checking
// (range / type / duplicate), single-cycle commit, and read-port arbitration.
module label_table_ctrl #(
  parameter int unsigned NLABELS = 13
) (
  input  logic              clk,
  input  logic              reset,
  label_table_ctrl_if.slave bus
);
  localparam int unsigned LBID_W = 12;
  localparam int unsigned TYP_W  = 6;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CODE_W = 2;

  localparam logic [LBID_W-1:0] N_IDS    = LBID_W'(NLABELS);
  localparam logic [LBID_W-1:0] LAST_IDX = LBID_W'(NLABELS - 1);

  localparam logic [CODE_W-1:0] CODE_RANGE  = CODE_W'(1);
  localparam logic [CODE_W-1:0] CODE_DUP    = CODE_W'(2);
  localparam logic [CODE_W-1:0] CODE_BADTYP = CODE_W'(3);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CHECK = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [LBID_W-1:0]   clr_idx_q, clr_idx_d;
  logic [LBID_W-1:0]   lbid_q, lbid_d;
  logic [TYP_W-1:0]    typ_q, typ_d;
  logic [DATA_W-1:0]   base_q, base_d;
  logic [DATA_W-1:0]   count_q, count_d;
  logic                err_q, err_d;
  logic [CODE_W-1:0]   err_code_q, err_code_d;
  logic [LBID_W-1:0]   err_lbid_q, err_lbid_d;
  logic [LBID_W-1:0]   defined_cnt_q, defined_cnt_d;

  logic                def_ready_c;
  logic                rd_stall_c;
  logic                busy_c;
  logic                we_c;
  logic [LBID_W-1:0]   tbl_lbid_c;
  logic [LBID_W-1:0]   tbl_lbidw_c;
  logic [TYP_W-1:0]    tbl_typw_c;
  logic [DATA_W-1:0]   tbl_basew_c;
  logic [DATA_W-1:0]   tbl_countw_c;
  logic                chk_err_c;
  logic [CODE_W-1:0]   chk_code_c;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      clr_idx_q     <= '0;
      lbid_q        <= '0;
      typ_q         <= '0;
      base_q        <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
      err_lbid_q    <= '0;
      defined_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      clr_idx_q     <= clr_idx_d;
      lbid_q        <= lbid_d;
      typ_q         <= typ_d;
      base_q        <= base_d;
      count_q       <= count_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      err_lbid_q    <= err_lbid_d;
      defined_cnt_q <= defined_cnt_d;
    end
  end

  // Next-state and table-port decode
  always_comb begin
    state_d       = state_q;
    clr_idx_d     = clr_idx_q;
    lbid_d        = lbid_q;
    typ_d         = typ_q;
    base_d        = base_q;
    count_d       = count_q;
    err_d         = err_q;
    err_code_d    = err_code_q;
    err_lbid_d    = err_lbid_q;
    defined_cnt_d = defined_cnt_q;

    def_ready_c   = 1'b0;
    rd_stall_c    = 1'b1;
    busy_c        = 1'b1;
    we_c          = 1'b0;
    tbl_lbid_c    = bus.rd_lbid;
    tbl_lbidw_c   = lbid_q;
    tbl_typw_c    = typ_q;
    tbl_basew_c   = base_q;
    tbl_countw_c  = count_q;
    chk_err_c     = 1'b0;
    chk_code_c    = '0;

    unique case (state_q)
      ST_CLEAR: begin
        we_c         = 1'b1;
        tbl_lbidw_c  = clr_idx_q;
        tbl_typw_c   = '0;
        tbl_basew_c  = '0;
        tbl_countw_c = '0;
        if (clr_idx_q == LAST_IDX) begin
          clr_idx_d = '0;
          state_d   = ST_IDLE;
        end else begin
          clr_idx_d = clr_idx_q + LBID_W'(1);
        end
      end

      ST_IDLE: begin
        busy_c      = 1'b0;
        rd_stall_c  = 1'b0;
        def_ready_c = ~bus.clear_req;
        // A clear request beats a simultaneous definition
        if (bus.clear_req) begin
          state_d       = ST_CLEAR;
          clr_idx_d     = '0;
          err_d         = 1'b0;
          err_code_d    = '0;
          err_lbid_d    = '0;
          defined_cnt_d = '0;
        end else if (bus.def_valid) begin
          lbid_d  = bus.def_lbid;
          typ_d   = bus.def_typ;
          base_d  = bus.def_base;
          count_d = bus.def_count;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        tbl_lbid_c = lbid_q;
        if (lbid_q >= N_IDS) begin
          chk_err_c  = 1'b1;
          chk_code_c = CODE_RANGE;
        end else if (typ_q == '0) begin
          chk_err_c  = 1'b1;
          chk_code_c = CODE_BADTYP;
        end else if (bus.tbl_typ != '0) begin
          chk_err_c  = 1'b1;
          chk_code_c = CODE_DUP;
        end
        if (chk_err_c) begin
          state_d = ST_IDLE;
          // Only the first error since the last clear is recorded
          if (!err_q) begin
            err_d      = 1'b1;
            err_code_d = chk_code_c;
            err_lbid_d = lbid_q;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        rd_stall_c    = 1'b0;
        we_c          = 1'b1;
        defined_cnt_d = defined_cnt_q + LBID_W'(1);
        state_d       = ST_IDLE;
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  assign bus.def_ready   = def_ready_c;
  assign bus.rd_stall    = rd_stall_c;
  assign bus.busy        = busy_c;
  assign bus.tbl_lbid    = tbl_lbid_c;
  assign bus.tbl_lbidw   = tbl_lbidw_c;
  assign bus.tbl_typw    = tbl_typw_c;
  assign bus.tbl_basew   = tbl_basew_c;
  assign bus.tbl_countw  = tbl_countw_c;
  // Write strobe is suppressed for the whole reset assertion
  assign bus.tbl_we      = we_c & ~reset;
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;
  assign bus.err_lbid    = err_lbid_q;
  assign bus.defined_cnt = defined_cnt_q;

endmodule

// File: tb/tb_label_table_ctrl.sv
// Bench for label_table_ctrl: behavioural table memory, sweep checker,
// table of definition vectors, and hand sequences for clear/reset corners.
module tb_label_table_ctrl;
  localparam int unsigned NL = 13;

  typedef struct packed {
    logic [11:0] lbid;
    logic [5:0]  typ;
    logic [15:0] base;
    logic [15:0] count;
    logic        exp_write;
    logic        exp_err;
    logic [1:0]  exp_code;
    logic [11:0] exp_elbid;
    logic [11:0] exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic mem_fill;
  int   tests;
  int   fails;
  int   nz_writes;
  logic [5:0] typ_mem [4096];
  vec_t vecs [8];

  label_table_ctrl_if bus ();

  label_table_ctrl #(.NLABELS(NL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Table storage: type field only, plus a count of non-zero writes
  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 4096; i++) typ_mem[i] <= 6'h2A;
      nz_writes <= 0;
    end else if (bus.tbl_we) begin
      typ_mem[bus.tbl_lbidw] <= bus.tbl_typw;
      if (bus.tbl_typw != 6'd0) nz_writes <= nz_writes + 1;
    end
  end

  assign bus.tbl_typ = typ_mem[bus.tbl_lbid];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Samples from the first CLEAR cycle until the first IDLE cycle
  task automatic check_sweep(input string tag);
    int cyc;
    int we_n;
    int bad;
    int nz;
    cyc = 0; we_n = 0; bad = 0; nz = 0;
    while (bus.busy && cyc < 40) begin
      if (bus.tbl_we) begin
        if (bus.tbl_lbidw != 12'(we_n) || bus.tbl_typw != 6'd0 ||
            bus.tbl_basew != 16'd0 || bus.tbl_countw != 16'd0) bad++;
        we_n++;
      end
      if (bus.def_ready || !bus.rd_stall) bad++;
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_sweep_cycles"}, 32'(cyc), NL);
    chk({tag, "_sweep_writes"}, 32'(we_n), NL);
    chk({tag, "_sweep_bad"}, 32'(bad), 0);
    chk({tag, "_idle_busy"}, bus.busy, 0);
    chk({tag, "_idle_ready"}, bus.def_ready, 1);
    chk({tag, "_idle_stall"}, bus.rd_stall, 0);
    chk({tag, "_idle_err"}, {bus.err, bus.err_code}, 0);
    chk({tag, "_idle_cnt"}, bus.defined_cnt, 0);
    for (int i = 0; i < int'(NL); i++) if (typ_mem[i] != 6'd0) nz++;
    chk({tag, "_mem_cleared"}, 32'(nz), 0);
  endtask

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (!bus.def_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_ready_wait"}, bus.def_ready, 1);
  endtask

  // Issue one definition and check CHECK / WRITE / return-to-IDLE cycles
  task automatic apply_vec(input vec_t v, input string tag);
    wait_ready(tag);
    bus.def_valid = 1'b1;
    bus.def_lbid  = v.lbid;
    bus.def_typ   = v.typ;
    bus.def_base  = v.base;
    bus.def_count = v.count;
    bus.rd_lbid   = v.lbid ^ 12'h001;
    @(negedge clk);
    bus.def_valid = 1'b0;
    chk({tag, "_chk_stall"}, bus.rd_stall, 1);
    chk({tag, "_chk_we"}, bus.tbl_we, 0);
    chk({tag, "_chk_rdaddr"}, bus.tbl_lbid, v.lbid);
    chk({tag, "_chk_ready"}, bus.def_ready, 0);
    @(negedge clk);
    chk({tag, "_n2_we"}, bus.tbl_we, v.exp_write);
    chk({tag, "_n2_stall"}, bus.rd_stall, 0);
    chk({tag, "_n2_rdaddr"}, bus.tbl_lbid, v.lbid ^ 12'h001);
    chk({tag, "_n2_ready"}, bus.def_ready, !v.exp_write);
    if (v.exp_write) begin
      chk({tag, "_wr_lbid"}, bus.tbl_lbidw, v.lbid);
      chk({tag, "_wr_typ"}, bus.tbl_typw, v.typ);
      chk({tag, "_wr_base"}, bus.tbl_basew, v.base);
      chk({tag, "_wr_count"}, bus.tbl_countw, v.count);
    end
    @(negedge clk);
    chk({tag, "_n3_ready"}, bus.def_ready, 1);
    chk({tag, "_n3_we"}, bus.tbl_we, 0);
    chk({tag, "_err"}, bus.err, v.exp_err);
    chk({tag, "_err_code"}, bus.err_code, v.exp_code);
    chk({tag, "_err_lbid"}, bus.err_lbid, v.exp_elbid);
    chk({tag, "_cnt"}, bus.defined_cnt, v.exp_cnt);
  endtask

  initial begin
    int snap;
    tests = 0;
    fails = 0;

    //            lbid    typ    base      count     wr   err  code elbid   cnt
    vecs[0] = '{12'd5,    6'd3,  16'h1000, 16'h0020, 1'b1, 1'b0, 2'd0, 12'd0, 12'd1};
    vecs[1] = '{12'd5,    6'd4,  16'hAAAA, 16'h0001, 1'b0, 1'b1, 2'd2, 12'd5, 12'd1};
    vecs[2] = '{12'd6,    6'd1,  16'h2000, 16'h0004, 1'b1, 1'b1, 2'd2, 12'd5, 12'd2};
    vecs[3] = '{12'd13,   6'd1,  16'h0000, 16'h0000, 1'b0, 1'b1, 2'd2, 12'd5, 12'd2};
    vecs[4] = '{12'd12,   6'd63, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 2'd2, 12'd5, 12'd3};
    vecs[5] = '{12'd0,    6'd7,  16'h0100, 16'h0008, 1'b1, 1'b1, 2'd2, 12'd5, 12'd4};
    vecs[6] = '{12'd2,    6'd0,  16'h0000, 16'h0000, 1'b0, 1'b1, 2'd2, 12'd5, 12'd4};
    vecs[7] = '{12'd4095, 6'd5,  16'h0300, 16'h0001, 1'b0, 1'b1, 2'd2, 12'd5, 12'd4};

    reset         = 1'b1;
    mem_fill      = 1'b1;
    bus.clear_req = 1'b0;
    bus.def_valid = 1'b0;
    bus.def_lbid  = '0;
    bus.def_typ   = '0;
    bus.def_base  = '0;
    bus.def_count = '0;
    bus.rd_lbid   = '0;

    @(negedge clk);
    @(negedge clk);
    mem_fill = 1'b0;
    chk("rst_we", bus.tbl_we, 0);
    chk("rst_busy", bus.busy, 1);
    chk("rst_stall", bus.rd_stall, 1);
    chk("rst_ready", bus.def_ready, 0);
    chk("rst_err", {bus.err, bus.err_code, bus.err_lbid}, 0);
    chk("rst_cnt", bus.defined_cnt, 0);

    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_sweep("rst");

    bus.rd_lbid = 12'd7;
    #1 chk("idle_rd_passthru", bus.tbl_lbid, 12'd7);

    for (int i = 0; i < 8; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Clear and definition in the same IDLE cycle: clear wins
    wait_ready("clr1");
    bus.clear_req = 1'b1;
    bus.def_valid = 1'b1;
    bus.def_lbid  = 12'd5;
    bus.def_typ   = 6'd9;
    @(negedge clk);
    bus.clear_req = 1'b0;
    bus.def_valid = 1'b0;
    check_sweep("clr1");
    apply_vec('{12'd5,  6'd2, 16'h0055, 16'h0003, 1'b1, 1'b0, 2'd0, 12'd0,  12'd1}, "redef5");
    apply_vec('{12'd20, 6'd0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'd1, 12'd20, 12'd1}, "range_vs_typ");

    // Fresh clear, then an invalid-type definition
    wait_ready("clr2");
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    check_sweep("clr2");
    apply_vec('{12'd2, 6'd0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'd3, 12'd2, 12'd0}, "badtyp");

    // Reset pulse during WRITE abandons the commit
    wait_ready("rstw");
    bus.def_valid = 1'b1;
    bus.def_lbid  = 12'd9;
    bus.def_typ   = 6'd5;
    bus.def_base  = 16'h1234;
    bus.def_count = 16'h0005;
    @(negedge clk);
    bus.def_valid = 1'b0;
    @(negedge clk);
    chk("rstw_pre_we", bus.tbl_we, 1);
    snap  = nz_writes;
    reset = 1'b1;
    #1;
    chk("rstw_we_forced", bus.tbl_we, 0);
    chk("rstw_busy", bus.busy, 1);
    chk("rstw_cnt", bus.defined_cnt, 0);
    @(posedge clk);
    #1;
    chk("rstw_no_write", 32'(nz_writes), 32'(snap));
    reset = 1'b0;
    @(negedge clk);
    check_sweep("rstw");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
